psk_link_ctrl: RTL and testbench

- Link sequencer for the PSK Tx/Rx loopback datapath.
- Accepts mode-change requests and drives MODE_CTRL to both Tx and Rx.
- On each mode change, holds the datapath in reset to flush it, then watches the Rx carrier-loop feedback (feedback_tdata) until the loop settles.
- Reports lock, loss-of-lock re-acquisitions and acquisition failure.

---
 rtl/psk_link_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_psk_link_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psk_link_ctrl.sv
// psk_link_ctrl - link sequencer for the PSK Tx/Rx loopback datapath.
//
// Takes one-hot mode-change requests, drives MODE_CTRL to Tx and Rx, holds the
// datapath in reset for a fixed flush period on every mode change, then
// watches the Rx carrier-loop feedback until it settles (lock), tracks it for
// loss of lock and times out into FAIL if acquisition never succeeds.
//
// Ports:
//   clk_32M768      in   1  system clock, 32.768 MHz
//   rst_32M768      in   1  asynchronous active-high reset
//   sym_en          in   1  sample strobe, one clock wide
//   mode_req        in   4  requested mode, one-hot (0001 BPSK, 0010 QPSK, 0100 MIX)
//   mode_req_vld    in   1  request valid
//   mode_req_rdy    out  1  request ready (IDLE, TRACK, FAIL)
//   feedback_tdata  in  16  signed Rx loop feedback
//   rx_valid        in   1  Rx output valid
//   MODE_CTRL       out  4  mode to Tx/Rx
//   dp_rst_n        out  1  active-low datapath reset
//   locked          out  1  loop locked
//   fail            out  1  acquisition timed out
//   cfg_err         out  1  one-cycle pulse on an invalid accepted request
//   state           out  3  current FSM state
//   relock_cnt      out  8  loss-of-lock count, saturating
module psk_link_ctrl #(
    parameter logic [3:0] RESET_MODE  = 4'b0001,
    parameter int         FLUSH_CYC   = 256,
    parameter int         LOCK_THRESH = 128,
    parameter int         LOCK_CNT    = 64,
    parameter int         LOSS_CNT    = 16,
    parameter int         ACQ_TIMEOUT = 4096
) (
    input  logic        clk_32M768,
    input  logic        rst_32M768,
    input  logic        sym_en,
    input  logic [3:0]  mode_req,
    input  logic        mode_req_vld,
    output logic        mode_req_rdy,
    input  logic [15:0] feedback_tdata,
    input  logic        rx_valid,
    output logic [3:0]  MODE_CTRL,
    output logic        dp_rst_n,
    output logic        locked,
    output logic        fail,
    output logic        cfg_err,
    output logic [2:0]  state,
    output logic [7:0]  relock_cnt
);

    localparam int FLUSH_W = $clog2(FLUSH_CYC + 1);
    localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int BAD_W   = $clog2(LOSS_CNT + 1);
    localparam int TMO_W   = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);
    localparam logic [GOOD_W-1:0]  GOOD_LAST  = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(LOSS_CNT - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(ACQ_TIMEOUT - 1);
    localparam logic [15:0]        THRESH     = 16'(LOCK_THRESH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_TRACK   = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    // Exactly one of the three defined mode bits, bit 3 clear.
    function automatic logic mode_is_valid(input logic [3:0] m);
        return (m == 4'b0001) || (m == 4'b0010) || (m == 4'b0100);
    endfunction

    // Magnitude of a signed 16-bit sample; -32768 saturates to 32767.
    function automatic logic [15:0] abs_sat(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'h8000) begin
            r = 16'h7FFF;
        end else if (v[15]) begin
            r = ~v + 16'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t               r_state,  w_state_nxt;
    logic [3:0]           r_mode,   w_mode_nxt;
    logic                 r_rdy,    w_rdy_nxt;
    logic                 r_dp_rst_n, w_dp_rst_n_nxt;
    logic                 r_locked, w_locked_nxt;
    logic                 r_fail,   w_fail_nxt;
    logic                 r_cfg_err, w_cfg_err_nxt;
    logic [7:0]           r_relock, w_relock_nxt;
    logic [FLUSH_W-1:0]   r_flush_cnt, w_flush_cnt_nxt;
    logic [GOOD_W-1:0]    r_good_cnt,  w_good_cnt_nxt;
    logic [BAD_W-1:0]     r_bad_cnt,   w_bad_cnt_nxt;
    logic [TMO_W-1:0]     r_tmo_cnt,   w_tmo_cnt_nxt;

    logic                 w_accept;
    logic                 w_good;

    assign w_accept = mode_req_vld && r_rdy;
    assign w_good   = rx_valid && (abs_sat(feedback_tdata) <= THRESH);

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_dp_rst_n_nxt  = r_dp_rst_n;
        w_locked_nxt    = r_locked;
        w_fail_nxt      = r_fail;
        w_cfg_err_nxt   = 1'b0;
        w_relock_nxt    = r_relock;
        w_flush_cnt_nxt = r_flush_cnt;
        w_good_cnt_nxt  = r_good_cnt;
        w_bad_cnt_nxt   = r_bad_cnt;
        w_tmo_cnt_nxt   = r_tmo_cnt;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_FLUSH: begin
                // sym_en is deliberately not looked at while flushing.
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_state_nxt     = ST_ACQUIRE;
                    w_dp_rst_n_nxt  = 1'b1;
                    w_flush_cnt_nxt = '0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt + FLUSH_W'(1);
                end
            end
            ST_ACQUIRE: begin
                if (sym_en) begin
                    // Lock is tested before timeout so it wins on a shared strobe.
                    if (w_good && (r_good_cnt == GOOD_LAST)) begin
                        w_state_nxt    = ST_TRACK;
                        w_locked_nxt   = 1'b1;
                        w_good_cnt_nxt = '0;
                        w_tmo_cnt_nxt  = '0;
                        w_bad_cnt_nxt  = '0;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        w_state_nxt    = ST_FAIL;
                        w_fail_nxt     = 1'b1;
                        w_dp_rst_n_nxt = 1'b0;
                        w_good_cnt_nxt = '0;
                        w_tmo_cnt_nxt  = '0;
                    end else begin
                        w_tmo_cnt_nxt  = r_tmo_cnt + TMO_W'(1);
                        w_good_cnt_nxt = w_good ? (r_good_cnt + GOOD_W'(1)) : '0;
                    end
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt;
                end
            end
            ST_TRACK: begin
                if (sym_en && !w_good) begin
                    if (r_bad_cnt == BAD_LAST) begin
                        // Loss of lock: re-acquire without flushing the datapath.
                        w_state_nxt    = ST_ACQUIRE;
                        w_locked_nxt   = 1'b0;
                        w_relock_nxt   = (r_relock == 8'hFF) ? r_relock : (r_relock + 8'd1);
                        w_bad_cnt_nxt  = '0;
                        w_good_cnt_nxt = '0;
                        w_tmo_cnt_nxt  = '0;
                    end else begin
                        w_bad_cnt_nxt = r_bad_cnt + BAD_W'(1);
                    end
                end else if (sym_en) begin
                    w_bad_cnt_nxt = '0;
                end else begin
                    w_bad_cnt_nxt = r_bad_cnt;
                end
            end
            ST_FAIL: begin
                w_fail_nxt     = 1'b1;
                w_dp_rst_n_nxt = 1'b0;
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_mode_nxt     = RESET_MODE;
                w_dp_rst_n_nxt = 1'b0;
                w_locked_nxt   = 1'b0;
                w_fail_nxt     = 1'b0;
            end
        endcase

        // An accepted valid request overrides anything the state logic decided,
        // including a simultaneous loss of lock (no relock is counted then).
        if (w_accept && mode_is_valid(mode_req)) begin
            w_state_nxt     = ST_FLUSH;
            w_mode_nxt      = mode_req;
            w_dp_rst_n_nxt  = 1'b0;
            w_locked_nxt    = 1'b0;
            w_fail_nxt      = 1'b0;
            w_relock_nxt    = r_relock;
            w_flush_cnt_nxt = '0;
            w_good_cnt_nxt  = '0;
            w_bad_cnt_nxt   = '0;
            w_tmo_cnt_nxt   = '0;
        end else if (w_accept) begin
            w_cfg_err_nxt = 1'b1;
        end else begin
            w_cfg_err_nxt = 1'b0;
        end

        w_rdy_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_TRACK) ||
                    (w_state_nxt == ST_FAIL);
    end

    // State and output registers.
    always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
        if (rst_32M768) begin
            r_state     <= ST_IDLE;
            r_mode      <= RESET_MODE;
            r_rdy       <= 1'b1;
            r_dp_rst_n  <= 1'b0;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_relock    <= 8'd0;
            r_flush_cnt <= '0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_rdy       <= w_rdy_nxt;
            r_dp_rst_n  <= w_dp_rst_n_nxt;
            r_locked    <= w_locked_nxt;
            r_fail      <= w_fail_nxt;
            r_cfg_err   <= w_cfg_err_nxt;
            r_relock    <= w_relock_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_good_cnt  <= w_good_cnt_nxt;
            r_bad_cnt   <= w_bad_cnt_nxt;
            r_tmo_cnt   <= w_tmo_cnt_nxt;
        end
    end

    assign mode_req_rdy = r_rdy;
    assign MODE_CTRL    = r_mode;
    assign dp_rst_n     = r_dp_rst_n;
    assign locked       = r_locked;
    assign fail         = r_fail;
    assign cfg_err      = r_cfg_err;
    assign state        = r_state;
    assign relock_cnt   = r_relock;

endmodule

// File: tb/tb_psk_link_ctrl.sv
// Directed, scoreboard-checked bench for psk_link_ctrl.
module tb_psk_link_ctrl;

    logic        clk_32M768 = 1'b0;
    logic        rst_32M768 = 1'b1;
    logic        sym_en = 1'b0;
    logic [3:0]  mode_req = 4'b0000;
    logic        mode_req_vld = 1'b0;
    logic        mode_req_rdy;
    logic [15:0] feedback_tdata = 16'd0;
    logic        rx_valid = 1'b0;
    logic [3:0]  MODE_CTRL;
    logic        dp_rst_n;
    logic        locked;
    logic        fail;
    logic        cfg_err;
    logic [2:0]  state;
    logic [7:0]  relock_cnt;

    int n_vec = 0;
    int n_mis = 0;

    string       tag_q[$];
    logic [15:0] exp_q[$];

    psk_link_ctrl dut (
        .clk_32M768     (clk_32M768),
        .rst_32M768     (rst_32M768),
        .sym_en         (sym_en),
        .mode_req       (mode_req),
        .mode_req_vld   (mode_req_vld),
        .mode_req_rdy   (mode_req_rdy),
        .feedback_tdata (feedback_tdata),
        .rx_valid       (rx_valid),
        .MODE_CTRL      (MODE_CTRL),
        .dp_rst_n       (dp_rst_n),
        .locked         (locked),
        .fail           (fail),
        .cfg_err        (cfg_err),
        .state          (state),
        .relock_cnt     (relock_cnt)
    );

    always #15 clk_32M768 = ~clk_32M768;

    task automatic step();
        @(posedge clk_32M768);
        #1;
    endtask

    task automatic push(input string t, input logic [15:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed 0x%0h expected nothing", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_mis++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", t, obs, e);
            end
        end
    endtask

    // One sym_en strobe; the caller decides what happens next cycle.
    task automatic pulse();
        sym_en = 1'b1;
        step();
        sym_en = 1'b0;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            pulse();
            step();
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget);
        for (int i = 0; i < budget && state !== target; i++) step();
    endtask

    logic [3:0] bad_modes [4];
    int         n_low;

    initial begin
        bad_modes = '{4'b0011, 4'b1000, 4'b0000, 4'b0111};

        // Reset values
        push("rst_state", 16'd0); push("rst_mode", 16'd1); push("rst_dp_rst_n", 16'd0);
        push("rst_locked", 16'd0); push("rst_fail", 16'd0); push("rst_cfg_err", 16'd0);
        push("rst_relock", 16'd0); push("rst_rdy", 16'd1);
        step(); step();
        pop(16'(state)); pop(16'(MODE_CTRL)); pop(16'(dp_rst_n));
        pop(16'(locked)); pop(16'(fail)); pop(16'(cfg_err));
        pop(16'(relock_cnt)); pop(16'(mode_req_rdy));

        // Request QPSK right at reset release: taken on the first edge
        rst_32M768 = 1'b0;
        mode_req = 4'b0010; mode_req_vld = 1'b1;
        push("acc_state", 16'd1); push("acc_mode", 16'd2); push("acc_dp_rst_n", 16'd0);
        push("acc_rdy", 16'd0);
        step();
        pop(16'(state)); pop(16'(MODE_CTRL)); pop(16'(dp_rst_n)); pop(16'(mode_req_rdy));
        mode_req_vld = 1'b0;

        // Flush length, with good strobes that must be ignored
        rx_valid = 1'b1; feedback_tdata = 16'd100;
        n_low = 1;
        push("flush_len", 16'd256); push("post_flush_state", 16'd2);
        for (int i = 0; i < 400; i++) begin
            sym_en = ~sym_en;
            step();
            if (dp_rst_n === 1'b0) n_low++;
            else break;
        end
        sym_en = 1'b0;
        pop(16'(n_low)); pop(16'(state));

        // Lock after exactly 64 good strobes
        push("pre_lock_locked", 16'd0); push("pre_lock_state", 16'd2);
        strobes(63);
        pop(16'(locked)); pop(16'(state));
        push("lock_locked", 16'd1); push("lock_state", 16'd3);
        pulse();
        pop(16'(locked)); pop(16'(state));
        step();

        // 15 bad then one boundary-good (|-128|) keeps TRACK
        feedback_tdata = 16'h8000;
        strobes(15);
        feedback_tdata = 16'hFF80;
        push("run_reset_state", 16'd3);
        strobes(1);
        pop(16'(state));

        // 16 bad (saturated -32768, then rx_valid=0) -> loss
        feedback_tdata = 16'h8000;
        strobes(8);
        rx_valid = 1'b0; feedback_tdata = 16'd0;
        strobes(7);
        push("loss_state", 16'd2); push("loss_locked", 16'd0);
        push("loss_relock", 16'd1); push("loss_dp_rst_n", 16'd1);
        pulse();
        pop(16'(state)); pop(16'(locked)); pop(16'(relock_cnt)); pop(16'(dp_rst_n));
        step();

        // Lock and timeout on the same strobe: lock wins (129 bad, 128 good)
        rx_valid = 1'b1; feedback_tdata = 16'd129;
        strobes(4032);
        feedback_tdata = 16'd128;
        strobes(63);
        push("pre_tie_state", 16'd2);
        pop(16'(state));
        push("tie_state", 16'd3); push("tie_locked", 16'd1); push("tie_fail", 16'd0);
        pulse();
        pop(16'(state)); pop(16'(locked)); pop(16'(fail));
        step();

        // Second loss, then timeout into FAIL
        feedback_tdata = 16'd1000;
        strobes(16);
        push("loss2_relock", 16'd2);
        pop(16'(relock_cnt));
        feedback_tdata = 16'd500;
        strobes(4095);
        push("pre_tmo_state", 16'd2); push("pre_tmo_dp_rst_n", 16'd1);
        pop(16'(state)); pop(16'(dp_rst_n));
        push("tmo_state", 16'd4); push("tmo_fail", 16'd1); push("tmo_dp_rst_n", 16'd0);
        push("tmo_locked", 16'd0);
        pulse();
        pop(16'(state)); pop(16'(fail)); pop(16'(dp_rst_n)); pop(16'(locked));

        // FAIL is sticky under good samples
        feedback_tdata = 16'd0;
        strobes(5);
        push("fail_hold_state", 16'd4); push("fail_hold_fail", 16'd1); push("fail_rdy", 16'd1);
        pop(16'(state)); pop(16'(fail)); pop(16'(mode_req_rdy));

        // Restart with BPSK
        mode_req = 4'b0001; mode_req_vld = 1'b1;
        push("restart_state", 16'd1); push("restart_fail", 16'd0); push("restart_mode", 16'd1);
        step();
        pop(16'(state)); pop(16'(fail)); pop(16'(MODE_CTRL));

        // Hold a MIX request through FLUSH and ACQUIRE
        mode_req = 4'b0100;
        step(); step();
        push("hold_flush_rdy", 16'd0); push("hold_flush_mode", 16'd1);
        pop(16'(mode_req_rdy)); pop(16'(MODE_CTRL));
        push("hold_acq_state", 16'd2); push("hold_acq_rdy", 16'd0);
        wait_state(3'd2, 300);
        pop(16'(state)); pop(16'(mode_req_rdy));
        strobes(63);
        push("hold_lock_state", 16'd3); push("hold_lock_rdy", 16'd1); push("hold_lock_mode", 16'd1);
        pulse();
        pop(16'(state)); pop(16'(mode_req_rdy)); pop(16'(MODE_CTRL));
        push("hold_take_state", 16'd1); push("hold_take_mode", 16'd4);
        step();
        pop(16'(state)); pop(16'(MODE_CTRL));
        mode_req_vld = 1'b0;

        // Back to TRACK
        push("relock_acq_state", 16'd2);
        wait_state(3'd2, 300);
        pop(16'(state));
        strobes(64);
        push("relock_track_state", 16'd3);
        pop(16'(state));

        // Invalid requests in TRACK
        for (int k = 0; k < 4; k++) begin
            mode_req = bad_modes[k]; mode_req_vld = 1'b1;
            push("cfg_err_hi", 16'd1); push("cfg_state", 16'd3); push("cfg_mode", 16'd4);
            step();
            pop(16'(cfg_err)); pop(16'(state)); pop(16'(MODE_CTRL));
            mode_req_vld = 1'b0;
            push("cfg_err_lo", 16'd0);
            step();
            pop(16'(cfg_err));
        end

        // Valid request on the same edge as a loss: FLUSH, no relock counted
        feedback_tdata = 16'd1000;
        strobes(15);
        sym_en = 1'b1; mode_req = 4'b0010; mode_req_vld = 1'b1;
        push("sim_state", 16'd1); push("sim_mode", 16'd2); push("sim_relock", 16'd2);
        push("sim_dp_rst_n", 16'd0);
        step();
        pop(16'(state)); pop(16'(MODE_CTRL)); pop(16'(relock_cnt)); pop(16'(dp_rst_n));
        sym_en = 1'b0; mode_req_vld = 1'b0;

        // Asynchronous reset mid-FLUSH
        step(); step(); step();
        rst_32M768 = 1'b1;
        #2;
        push("arst_state", 16'd0); push("arst_mode", 16'd1); push("arst_dp_rst_n", 16'd0);
        push("arst_relock", 16'd0); push("arst_rdy", 16'd1); push("arst_locked", 16'd0);
        pop(16'(state)); pop(16'(MODE_CTRL)); pop(16'(dp_rst_n));
        pop(16'(relock_cnt)); pop(16'(mode_req_rdy)); pop(16'(locked));
        step();
        rst_32M768 = 1'b0;
        push("idle_after_rst", 16'd0);
        step();
        pop(16'(state));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
